// File: rtl/ppu_cpu_pkg.sv
// Shared CPU/PPU definitions for the sprite DMA path: DMA state encoding,
// the bus addresses the engine knows about, and the get/put alignment rule.
package ppu_cpu_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    ALIGN = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4
  } dma_state_t;

  localparam logic [15:0] OAM_PORT_ADDR = 16'h2004;
  localparam logic [15:0] DMA_REG_ADDR  = 16'h4014;

  // The HALT cycle's parity decides the exit: parity 1 now means the next
  // cycle is a get (parity 0) cycle, so the first read can start at once.
  function automatic dma_state_t halt_exit(input logic parity);
    dma_state_t nxt;
    if (parity) begin
      nxt = READ;
    end else begin
      nxt = ALIGN;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/oam_dma_controller.sv
// Sprite DMA engine: a $4014 write halts the CPU and copies page P into PPU
// OAM as alternating read/write CPU-bus cycles aligned to the get/put parity.
module oam_dma_controller #(
  parameter logic [15:0] OAM_PORT_ADDR  = 16'h2004,
  parameter int          TRANSFER_COUNT = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        clock_EN,
  input  logic        regWrite_EN,
  input  logic [7:0]  cpuData_IN,
  input  logic [7:0]  busData_IN,
  output logic        cpuHalt_OUT,
  output logic [15:0] busAddress_OUT,
  output logic        busRead_OUT,
  output logic        oamWrite_OUT,
  output logic [7:0]  oamData_OUT,
  output logic        dmaActive_OUT
);

  import ppu_cpu_pkg::*;

  localparam logic [7:0] LAST_INDEX = 8'(TRANSFER_COUNT - 1);

  dma_state_t state;
  logic       parity;
  logic [7:0] page;
  logic [7:0] index;
  logic [7:0] data_latch;

  // Sequencer: every register advances only on CPU-cycle enabled edges.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      parity     <= 1'b0;
      page       <= 8'h00;
      index      <= 8'h00;
      data_latch <= 8'h00;
    end else if (clock_EN) begin
      parity <= ~parity;
      case (state)
        IDLE: begin
          if (regWrite_EN) begin
            page  <= cpuData_IN;
            index <= 8'h00;
            state <= HALT;
          end
        end
        HALT: begin
          state <= halt_exit(parity);
        end
        ALIGN: begin
          state <= READ;
        end
        READ: begin
          data_latch <= busData_IN;
          state      <= WRITE;
        end
        WRITE: begin
          index <= index + 8'd1;
          if (index == LAST_INDEX) begin
            state <= IDLE;
          end else begin
            state <= READ;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Bus and handshake outputs decode straight from state so reset clears them at once.
  always_comb begin
    cpuHalt_OUT    = 1'b0;
    dmaActive_OUT  = 1'b0;
    busAddress_OUT = 16'h0000;
    busRead_OUT    = 1'b0;
    oamWrite_OUT   = 1'b0;
    case (state)
      HALT, ALIGN: begin
        cpuHalt_OUT   = 1'b1;
        dmaActive_OUT = 1'b1;
      end
      READ: begin
        cpuHalt_OUT    = 1'b1;
        dmaActive_OUT  = 1'b1;
        busAddress_OUT = {page, index};
        busRead_OUT    = 1'b1;
      end
      WRITE: begin
        cpuHalt_OUT    = 1'b1;
        dmaActive_OUT  = 1'b1;
        busAddress_OUT = OAM_PORT_ADDR;
        oamWrite_OUT   = 1'b1;
      end
      default: begin
        cpuHalt_OUT = 1'b0;
      end
    endcase
  end

  assign oamData_OUT = data_latch;

endmodule

// File: tb/tb_oam_dma_controller.sv
// Directed bench for the sprite DMA engine: cycle-by-cycle comparison of bus
// activity against a reference sequence built from page, alignment and memory contents.
module tb_oam_dma_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic        clock_EN;
  logic        regWrite_EN;
  logic [7:0]  cpuData_IN;
  logic [7:0]  busData_IN;
  logic        cpuHalt_OUT;
  logic [15:0] busAddress_OUT;
  logic        busRead_OUT;
  logic        oamWrite_OUT;
  logic [7:0]  oamData_OUT;
  logic        dmaActive_OUT;

  int         n_assert = 0;
  int         n_fail   = 0;
  bit         par      = 1'b0;
  logic [7:0] last_data = 8'h00;

  oam_dma_controller dut (
    .clock          (clock),
    .reset          (reset),
    .clock_EN       (clock_EN),
    .regWrite_EN    (regWrite_EN),
    .cpuData_IN     (cpuData_IN),
    .busData_IN     (busData_IN),
    .cpuHalt_OUT    (cpuHalt_OUT),
    .busAddress_OUT (busAddress_OUT),
    .busRead_OUT    (busRead_OUT),
    .oamWrite_OUT   (oamWrite_OUT),
    .oamData_OUT    (oamData_OUT),
    .dmaActive_OUT  (dmaActive_OUT)
  );

  always #5 clock = ~clock;

  // Memory image: page $02 holds $00..$FF, other pages are scrambled per page.
  function automatic logic [7:0] mem_byte(input logic [15:0] addr);
    return addr[7:0] ^ (addr[15:8] - 8'h02);
  endfunction

  assign busData_IN = mem_byte(busAddress_OUT);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    if (clock_EN && !reset) par = ~par;
  endtask

  task automatic wait_par(input bit want);
    clock_EN = 1'b1;
    if (par != want) step();
  endtask

  // Reference outputs for CPU cycle n after acceptance; ctrl = {halt, active, read, write}.
  task automatic check_cycle(input logic [7:0] page, input int a, input int n);
    logic [3:0]  ctrl;
    logic [15:0] addr;
    logic [7:0]  data;
    int m;
    int i;
    if (n <= a) begin
      ctrl = 4'b1100; addr = 16'h0000; data = last_data;
    end else begin
      m = n - 1 - a;
      i = m / 2;
      if (m >= 512) begin
        ctrl = 4'b0000; addr = 16'h0000; data = mem_byte({page, 8'hFF});
      end else if (m % 2 == 0) begin
        ctrl = 4'b1110; addr = {page, 8'(i)};
        data = (i == 0) ? last_data : mem_byte({page, 8'(i - 1)});
      end else begin
        ctrl = 4'b1101; addr = 16'h2004; data = mem_byte({page, 8'(i)});
      end
    end
    check($sformatf("p%02h n%0d ctrl", page, n),
          32'({cpuHalt_OUT, dmaActive_OUT, busRead_OUT, oamWrite_OUT}), 32'(ctrl));
    check($sformatf("p%02h n%0d addr", page, n), 32'(busAddress_OUT), 32'(addr));
    check($sformatf("p%02h n%0d data", page, n), 32'(oamData_OUT), 32'(data));
  endtask

  // One full DMA; exp_halt is 513 (aligned) or 514 (one ALIGN cycle).
  task automatic transfer(input logic [7:0] page, input int exp_halt, input bit gate,
                          input bit retrig, input int stop_at);
    int a;
    int n;
    a = exp_halt - 513;
    n = 0;
    clock_EN    = 1'b1;
    regWrite_EN = 1'b1;
    cpuData_IN  = page;
    step();
    regWrite_EN = 1'b0;
    cpuData_IN  = 8'h00;
    while (cpuHalt_OUT === 1'b1 && n < 700) begin
      if (n == stop_at) return;
      check_cycle(page, a, n);
      if (retrig && n == 100) begin
        regWrite_EN = 1'b1;
        cpuData_IN  = 8'h07;
      end
      if (gate && (n % 3 == 2)) begin
        clock_EN = 1'b0;
        repeat (5) begin
          step();
          check_cycle(page, a, n);
        end
        clock_EN = 1'b1;
      end
      step();
      regWrite_EN = 1'b0;
      cpuData_IN  = 8'h00;
      n++;
    end
    check($sformatf("p%02h halt_cycles", page), 32'(n), 32'(exp_halt));
    check_cycle(page, a, exp_halt);
    last_data = mem_byte({page, 8'hFF});
  endtask

  initial begin
    reset       = 1'b1;
    clock_EN    = 1'b0;
    regWrite_EN = 1'b0;
    cpuData_IN  = 8'h00;
    #1;
    check("reset_ctrl", 32'({cpuHalt_OUT, dmaActive_OUT, busRead_OUT, oamWrite_OUT}), 32'h0);
    check("reset_addr", 32'(busAddress_OUT), 32'h0);
    check("reset_data", 32'(oamData_OUT), 32'h0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    par   = 1'b0;

    // A $4014 write without a CPU-cycle enable must not start anything.
    regWrite_EN = 1'b1;
    cpuData_IN  = 8'h09;
    repeat (3) begin
      step();
      check("gated_write_ignored", 32'({cpuHalt_OUT, dmaActive_OUT}), 32'h0);
    end
    regWrite_EN = 1'b0;
    clock_EN    = 1'b1;
    repeat (2) begin
      step();
      check("idle_no_halt", 32'({cpuHalt_OUT, busRead_OUT, oamWrite_OUT}), 32'h0);
    end

    wait_par(1'b0); transfer(8'h02, 513, 1'b0, 1'b0, -1);
    wait_par(1'b1); transfer(8'h02, 514, 1'b0, 1'b0, -1);
    wait_par(1'b0); transfer(8'h03, 513, 1'b0, 1'b1, -1);
    wait_par(1'b1); transfer(8'h04, 514, 1'b1, 1'b0, -1);
    wait_par(1'b0); transfer(8'h06, 513, 1'b1, 1'b0, -1);
    wait_par(1'b0); transfer(8'hFF, 513, 1'b0, 1'b0, -1);

    // Abort in the READ of index $41, right after the write of index $40.
    wait_par(1'b0); transfer(8'h05, 513, 1'b0, 1'b0, 131);
    check("pre_reset_read", 32'({busRead_OUT, busAddress_OUT}), 32'h1_0541);
    #3;
    reset = 1'b1;
    #1;
    check("async_reset_ctrl", 32'({cpuHalt_OUT, dmaActive_OUT, busRead_OUT, oamWrite_OUT}), 32'h0);
    check("async_reset_addr", 32'(busAddress_OUT), 32'h0);
    check("async_reset_data", 32'(oamData_OUT), 32'h0);
    step();
    step();
    reset = 1'b0;
    par   = 1'b0;
    repeat (20) begin
      step();
      check("post_reset_idle", 32'({cpuHalt_OUT, dmaActive_OUT, busRead_OUT, oamWrite_OUT}), 32'h0);
      check("post_reset_data", 32'(oamData_OUT), 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
